regfile_mp: RTL

Parametrised multi-port register file with write-port priority, optional write-to-read bypass and a per-register pending-write scoreboard. It succeeds the fixed 8x16, single-write-port register file in the CPU datapath. It supports two writeback sources, for example the ALU and a multi-cycle unit or memory load. Decode uses the scoreboard to stall on registers whose results are still outstanding.

---
 rtl/regfile_mp.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with two write ports (A has priority),
// optional write-to-read bypass and a per-register pending-write scoreboard
// that decode uses to stall on results that are still outstanding.
module regfile_mp #(
    parameter int               WIDTH   = 16,
    parameter int               ADDR_W  = 3,
    parameter int               BYPASS  = 1,
    parameter int               ZERO_R0 = 0,
    parameter logic [WIDTH-1:0] RST_R0  = 'h0001,
    parameter logic [WIDTH-1:0] RST_R1  = 'h0001
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rega,
    input  logic [ADDR_W-1:0]        regb,
    output logic [WIDTH-1:0]         read1,
    output logic [WIDTH-1:0]         read2,
    output logic                     busy1,
    output logic                     busy2,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_reg,
    input  logic [WIDTH-1:0]         wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_reg,
    input  logic [WIDTH-1:0]         wb_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_reg,
    output logic [(2**ADDR_W)-1:0]   busy_vec,
    output logic                     conflict
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy_nxt;

    logic wa_ok;      // port A write that actually lands
    logic wb_live;    // port B enabled and targeting a writable register
    logic wb_ok;      // port B write that actually lands (not shadowed by A)
    logic collide;    // both ports aimed at the same writable register
    logic rsv_ok;     // reserve that actually takes effect

    // Register 0 is read-only when hard-wired to zero
    function automatic logic is_locked(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    function automatic logic [WIDTH-1:0] reset_value(input int idx);
        if (idx == 0)
            return (ZERO_R0 != 0) ? '0 : RST_R0;
        else if (idx == 1)
            return RST_R1;
        else
            return '0;
    endfunction

    // Stored value, optionally overridden by a same-cycle write (port A first)
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] a,
        input logic [WIDTH-1:0]  stored,
        input logic              a_ok,
        input logic [ADDR_W-1:0] a_reg,
        input logic [WIDTH-1:0]  a_data,
        input logic              b_ok,
        input logic [ADDR_W-1:0] b_reg,
        input logic [WIDTH-1:0]  b_data
    );
        logic [WIDTH-1:0] v;
        v = stored;
        if (BYPASS != 0) begin
            if (a_ok && (a_reg == a))
                v = a_data;
            else if (b_ok && (b_reg == a))
                v = b_data;
        end
        if (is_locked(a))
            v = '0;
        return v;
    endfunction

    // Qualify write/reserve requests; port B yields to port A on the same register
    always_comb begin
        wa_ok   = wa_en && !is_locked(wa_reg);
        wb_live = wb_en && !is_locked(wb_reg);
        collide = wa_ok && wb_live && (wa_reg == wb_reg);
        wb_ok   = wb_live && !collide;
        rsv_ok  = rsv_en && !is_locked(rsv_reg);
    end

    // Register storage; reset overrides any same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= reset_value(i);
        end else begin
            if (wb_ok)
                regs[wb_reg] <= wb_data;
            if (wa_ok)
                regs[wa_reg] <= wa_data;
        end
    end

    // Scoreboard next state: a new reservation beats a clearing write
    always_comb begin
        busy_nxt = busy_vec;
        for (int i = 0; i < DEPTH; i++) begin
            if (rsv_ok && (rsv_reg == ADDR_W'(i)))
                busy_nxt[i] = 1'b1;
            else if ((wa_ok && (wa_reg == ADDR_W'(i))) ||
                     (wb_ok && (wb_reg == ADDR_W'(i))))
                busy_nxt[i] = 1'b0;
        end
    end

    // Scoreboard and conflict flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec <= '0;
            conflict <= 1'b0;
        end else begin
            busy_vec <= busy_nxt;
            conflict <= collide;
        end
    end

    // Combinational read ports; busy bits come from the registered scoreboard only
    always_comb begin
        read1 = read_port(rega, regs[rega], wa_ok, wa_reg, wa_data, wb_ok, wb_reg, wb_data);
        read2 = read_port(regb, regs[regb], wa_ok, wa_reg, wa_data, wb_ok, wb_reg, wb_data);
        busy1 = busy_vec[rega];
        busy2 = busy_vec[regb];
    end

endmodule
